// File: rtl/gc_adc_pkg.sv
// Shared types and constants for the stick-axis ADC scan scheduler.
package gc_adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    START   = 2'd2,
    CONVERT = 2'd3
  } state_t;

  localparam logic [1:0] AX_JX = 2'd0;
  localparam logic [1:0] AX_JY = 2'd1;
  localparam logic [1:0] AX_CX = 2'd2;
  localparam logic [1:0] AX_CY = 2'd3;

  localparam logic [7:0] CENTER_DEFAULT = 8'h7F;

endpackage

// File: rtl/adc_rr_pick.sv
// Round-robin picker: first enabled axis strictly after ptr, wrapping mod 4.
module adc_rr_pick (
  input  logic [1:0] ptr,
  input  logic [3:0] en,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk ptr+1 .. ptr+4 and keep the first enabled candidate.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = cand + 2'd1;
      if (!found && en[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// Time-shares one SAR ADC across the four stick axes and publishes
// per-axis 8-bit results, frozen while a GC response is transmitting.
module adc_scan_sched
  import gc_adc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 400,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  CENTER         = CENTER_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] CH_EN,
  input  logic       HOLD,
  output logic       ADC_START,
  input  logic       ADC_DONE,
  input  logic [7:0] ADC_DATA,
  output logic [1:0] CH_SEL,
  output logic [7:0] J_STICK_X,
  output logic [7:0] J_STICK_Y,
  output logic [7:0] C_STICK_X,
  output logic [7:0] C_STICK_Y,
  output logic [3:0] CH_VALID,
  output logic [3:0] TIMEOUT_ERR,
  output logic       SCAN_DONE
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);
  // Timeout counter holds cycles elapsed since ADC_START rose.
  localparam logic [TW-1:0] TO_FIRST = TW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [1:0]      ch_sel_q, ch_sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [TW-1:0]   to_q, to_d;
  logic            adc_start_q, adc_start_d;
  logic            scan_done_q, scan_done_d;
  logic [3:0][7:0] shadow_q, shadow_d;
  logic [3:0][7:0] out_q, out_d;
  logic [3:0]      valid_q, valid_d;
  logic [3:0]      err_q, err_d;

  logic            pick_found_s;
  logic [1:0]      pick_idx_s;
  logic [3:0]      higher_en_s;
  logic            higher_found_s;
  logic [1:0]      higher_idx_s;
  logic            more_s;

  adc_rr_pick u_pick (
    .ptr   (ptr_q),
    .en    (CH_EN),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Same picker restricted to axes above CH_SEL decides end-of-pass.
  assign higher_en_s = CH_EN & 4'(4'b1110 << ch_sel_q);

  adc_rr_pick u_higher (
    .ptr   (ch_sel_q),
    .en    (higher_en_s),
    .found (higher_found_s),
    .idx   (higher_idx_s)
  );

  assign more_s = higher_found_s && (higher_idx_s > ch_sel_q);

  // Next-state and datapath computation for the scan FSM.
  always_comb begin
    state_d     = state_q;
    ch_sel_d    = ch_sel_q;
    ptr_d       = ptr_q;
    settle_d    = settle_q;
    to_d        = to_q;
    adc_start_d = 1'b0;
    scan_done_d = 1'b0;
    shadow_d    = shadow_q;
    valid_d     = valid_q;
    err_d       = err_q;
    out_d       = HOLD ? out_q : shadow_q;

    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          ch_sel_d = pick_idx_s;
          ptr_d    = pick_idx_s;
          settle_d = SETTLE_LOAD;
          state_d  = SETTLE;
        end else begin
          state_d  = IDLE;
        end
      end
      SETTLE: begin
        if (settle_q <= SW'(1)) begin
          state_d     = START;
          adc_start_d = 1'b1;
        end else begin
          settle_d    = settle_q - SW'(1);
        end
      end
      START: begin
        to_d    = TO_FIRST;
        state_d = CONVERT;
      end
      CONVERT: begin
        if (ADC_DONE) begin
          shadow_d[ch_sel_q] = ADC_DATA;
          valid_d[ch_sel_q]  = 1'b1;
          err_d[ch_sel_q]    = 1'b0;
          scan_done_d        = !more_s;
          state_d            = IDLE;
        end else if (to_q == TO_LAST) begin
          err_d[ch_sel_q]    = 1'b1;
          scan_done_d        = !more_s;
          state_d            = IDLE;
        end else begin
          to_d               = to_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      ch_sel_q    <= AX_JX;
      ptr_q       <= AX_CY;
      settle_q    <= '0;
      to_q        <= '0;
      adc_start_q <= 1'b0;
      scan_done_q <= 1'b0;
      shadow_q    <= {4{CENTER}};
      out_q       <= {4{CENTER}};
      valid_q     <= 4'b0000;
      err_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      ch_sel_q    <= ch_sel_d;
      ptr_q       <= ptr_d;
      settle_q    <= settle_d;
      to_q        <= to_d;
      adc_start_q <= adc_start_d;
      scan_done_q <= scan_done_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign ADC_START   = adc_start_q;
  assign SCAN_DONE   = scan_done_q;
  assign CH_SEL      = ch_sel_q;
  assign CH_VALID    = valid_q;
  assign TIMEOUT_ERR = err_q;
  assign J_STICK_X   = out_q[AX_JX];
  assign J_STICK_Y   = out_q[AX_JY];
  assign C_STICK_X   = out_q[AX_CX];
  assign C_STICK_Y   = out_q[AX_CY];

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed bench for adc_scan_sched: table of scan passes plus hand
// sequences for timeout, DONE/expiry race, HOLD freeze and mid-conversion reset.
module tb_adc_scan_sched;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] CH_EN;
  logic       HOLD;
  logic       ADC_START;
  logic       ADC_DONE;
  logic [7:0] ADC_DATA;
  logic [1:0] CH_SEL;
  logic [7:0] J_STICK_X, J_STICK_Y, C_STICK_X, C_STICK_Y;
  logic [3:0] CH_VALID, TIMEOUT_ERR;
  logic       SCAN_DONE;

  int n_cmp  = 0;
  int n_fail = 0;

  adc_scan_sched #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (16),
    .CENTER         (8'h7F)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .CH_EN       (CH_EN),
    .HOLD        (HOLD),
    .ADC_START   (ADC_START),
    .ADC_DONE    (ADC_DONE),
    .ADC_DATA    (ADC_DATA),
    .CH_SEL      (CH_SEL),
    .J_STICK_X   (J_STICK_X),
    .J_STICK_Y   (J_STICK_Y),
    .C_STICK_X   (C_STICK_X),
    .C_STICK_Y   (C_STICK_Y),
    .CH_VALID    (CH_VALID),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .SCAN_DONE   (SCAN_DONE)
  );

  always #5 CLK = ~CLK;

  // SAR model: answers adc_delay edges after START with adc_base+axis,
  // unless the axis is marked silent.
  int         adc_delay  = 10;
  logic [7:0] adc_base   = 8'h00;
  logic [3:0] adc_silent = 4'h0;
  int         model_cnt  = 0;
  logic [1:0] model_sel  = 2'd0;

  initial begin
    ADC_DONE = 1'b0;
    ADC_DATA = 8'h00;
    forever begin
      @(posedge CLK);
      #2;
      ADC_DONE = 1'b0;
      if (model_cnt > 0) begin
        model_cnt = model_cnt - 1;
        if (model_cnt == 0) begin
          ADC_DONE = 1'b1;
          ADC_DATA = adc_base + 8'(model_sel);
        end
      end
      if (ADC_START === 1'b1 && adc_silent[CH_SEL] !== 1'b1) begin
        model_cnt = adc_delay - 1;
        model_sel = CH_SEL;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (ADC_START !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    n_cmp++;
    if (ADC_START !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: no ADC_START within 200 cycles", name);
    end
  endtask

  task automatic wait_scan(input string name);
    int k;
    k = 0;
    while (SCAN_DONE !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    n_cmp++;
    if (SCAN_DONE !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: no SCAN_DONE within 400 cycles", name);
    end
  endtask

  function automatic logic [31:0] outs();
    return {C_STICK_Y, C_STICK_X, J_STICK_Y, J_STICK_X};
  endfunction

  typedef struct {
    logic [3:0]  ch_en;
    logic [3:0]  silent;
    logic [7:0]  base;
    int          n_st;
    logic [7:0]  seq;    // expected CH_SEL at each START, 2 bits each, first in [1:0]
    logic [31:0] outs;   // {CY, CX, JY, JX}
    logic [3:0]  valid;
    logic [3:0]  err;
  } vec_t;

  vec_t vec [7];

  initial begin
    logic [7:0] seq;
    int         n_st;
    logic       seen;

    vec[0] = '{4'hA, 4'h0, 8'h20, 2, 8'h0D, 32'h237F217F, 4'hA, 4'h0};
    vec[1] = '{4'hF, 4'h0, 8'h10, 4, 8'hE4, 32'h13121110, 4'hF, 4'h0};
    vec[2] = '{4'h5, 4'h0, 8'h30, 2, 8'h08, 32'h13321130, 4'hF, 4'h0};
    vec[3] = '{4'h4, 4'h0, 8'h40, 1, 8'h02, 32'h13421130, 4'hF, 4'h0};
    vec[4] = '{4'hF, 4'h0, 8'h50, 1, 8'h03, 32'h53421130, 4'hF, 4'h0};
    vec[5] = '{4'hF, 4'h4, 8'h60, 4, 8'hE4, 32'h63426160, 4'hF, 4'h4};
    vec[6] = '{4'h4, 4'h0, 8'h70, 1, 8'h02, 32'h63726160, 4'hF, 4'h0};

    RESET = 1'b0;
    CH_EN = 4'h0;
    HOLD  = 1'b0;
    tick();
    tick();
    chk("reset_ctrl", {20'h0, CH_SEL, ADC_START, SCAN_DONE, CH_VALID, TIMEOUT_ERR}, 32'h0);
    chk("reset_outs", outs(), 32'h7F7F7F7F);
    RESET = 1'b1;
    tick();
    chk("idle_no_start", {31'h0, ADC_START}, 32'h0);

    for (int r = 0; r < 7; r++) begin
      adc_base   = vec[r].base;
      adc_silent = vec[r].silent;
      adc_delay  = 10;
      CH_EN      = vec[r].ch_en;
      n_st       = 0;
      seq        = 8'h00;
      seen       = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
        tick();
        if (ADC_START === 1'b1) begin
          if (n_st < 4) seq[2*n_st +: 2] = CH_SEL;
          n_st++;
        end
        if (SCAN_DONE === 1'b1) seen = 1'b1;
      end
      CH_EN = 4'h0;
      chk($sformatf("v%0d_scan_done", r), {31'h0, seen}, 32'h1);
      chk($sformatf("v%0d_n_starts", r), 32'(n_st), 32'(vec[r].n_st));
      chk($sformatf("v%0d_sel_seq", r), {24'h0, seq}, {24'h0, vec[r].seq});
      tick();
      chk($sformatf("v%0d_outs", r), outs(), vec[r].outs);
      chk($sformatf("v%0d_valid", r), {28'h0, CH_VALID}, {28'h0, vec[r].valid});
      chk($sformatf("v%0d_err", r), {28'h0, TIMEOUT_ERR}, {28'h0, vec[r].err});
      chk($sformatf("v%0d_scan_pulse", r), {31'h0, SCAN_DONE}, 32'h0);
    end

    // Timeout lands exactly 16 cycles after START.
    adc_silent = 4'h1;
    CH_EN      = 4'h1;
    wait_start("to_start");
    chk("to_sel", {30'h0, CH_SEL}, 32'h0);
    for (int k = 0; k < 15; k++) tick();
    chk("to_err_before", {28'h0, TIMEOUT_ERR}, 32'h0);
    tick();
    chk("to_err_at16", {28'h0, TIMEOUT_ERR}, 32'h1);
    chk("to_scan_done", {31'h0, SCAN_DONE}, 32'h1);
    CH_EN = 4'h0;
    tick();
    chk("to_shadow_kept", {24'h0, J_STICK_X}, 32'h60);

    // DONE coincident with expiry: data wins, error clears.
    adc_silent = 4'h0;
    adc_delay  = 16;
    adc_base   = 8'h70;
    CH_EN      = 4'h1;
    wait_scan("race_scan");
    CH_EN = 4'h0;
    chk("race_err", {28'h0, TIMEOUT_ERR}, 32'h0);
    tick();
    chk("race_data", {24'h0, J_STICK_X}, 32'h70);

    // HOLD freezes outputs but not scanning.
    adc_delay = 10;
    adc_base  = 8'hA5;
    HOLD      = 1'b1;
    CH_EN     = 4'h1;
    wait_scan("hold_scan");
    CH_EN = 4'h0;
    for (int k = 0; k < 3; k++) tick();
    chk("hold_frozen", {24'h0, J_STICK_X}, 32'h70);
    HOLD = 1'b0;
    chk("hold_still_before_edge", {24'h0, J_STICK_X}, 32'h70);
    tick();
    chk("hold_released", {24'h0, J_STICK_X}, 32'hA5);

    // Reset during CONVERT; the stale DONE arrives while IDLE.
    adc_base = 8'h55;
    CH_EN    = 4'h1;
    wait_start("rst_start");
    tick();
    tick();
    RESET = 1'b0;
    CH_EN = 4'h0;
    tick();
    tick();
    chk("rst_outs", outs(), 32'h7F7F7F7F);
    chk("rst_ctrl", {20'h0, CH_SEL, ADC_START, SCAN_DONE, CH_VALID, TIMEOUT_ERR}, 32'h0);
    RESET = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("rst_late_done_valid", {28'h0, CH_VALID}, 32'h0);
    chk("rst_late_done_outs", outs(), 32'h7F7F7F7F);
    CH_EN = 4'hF;
    wait_start("rst_next_start");
    chk("rst_next_sel", {30'h0, CH_SEL}, 32'h0);
    CH_EN = 4'h0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
